// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between a pipeline data port and its memory.
// The master is the requester; the slave is the memory-side responder.
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddress;
  logic [31:0] ReqWriteData;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespReadData;
  logic        RespError;

  modport master (
    output ReqValid, ReqWrite, ReqAddress, ReqWriteData, ReqSize, ReqSigned, RespReady,
    input  ReqReady, RespValid, RespReadData, RespError
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddress, ReqWriteData, ReqSize, ReqSigned, RespReady,
    output ReqReady, RespValid, RespReadData, RespError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed wait before the access,
// byte/half/word little-endian lanes with misalignment, range and size error reporting.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 Clk,
  input logic                 Reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IdxW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DepthW = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WaitW  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} stateE;

  stateE       stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic        writeQ, writeD;
  logic [31:0] addrQ, addrD;
  logic [31:0] wdataQ, wdataD;
  logic [1:0]  sizeQ, sizeD;
  logic        signedQ, signedD;
  logic [31:0] rdataQ, rdataD;
  logic        errQ, errD;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [IdxW-1:0] idx;
  logic            inRange;
  logic            accessErr;
  logic [31:0]     memWord;
  logic [31:0]     loadData;
  logic [31:0]     storeWord;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;
  logic            memWe;

  assign idx     = addrQ[IdxW+1:2];
  assign inRange = {2'b00, addrQ[31:2]} < DepthW;
  assign memWord = inRange ? mem[idx] : '0;

  always_comb begin
    accessErr = 1'b0;
    unique case (sizeQ)
      2'b00:   accessErr = 1'b0;
      2'b01:   accessErr = addrQ[0];
      2'b10:   accessErr = addrQ[1:0] != 2'b00;
      default: accessErr = 1'b1;
    endcase
    if (!inRange) accessErr = 1'b1;
  end

  always_comb begin
    byteSel  = memWord[{addrQ[1:0], 3'b000} +: 8];
    halfSel  = memWord[{addrQ[1], 4'b0000} +: 16];
    loadData = '0;
    case (sizeQ)
      2'b00:   loadData = {{24{signedQ & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{signedQ & halfSel[15]}}, halfSel};
      2'b10:   loadData = memWord;
      default: loadData = '0;
    endcase
  end

  // Read-modify-write merge so only the addressed lanes change.
  always_comb begin
    storeWord = memWord;
    case (sizeQ)
      2'b00:   storeWord[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
      2'b01:   storeWord[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
      2'b10:   storeWord = wdataQ;
      default: storeWord = memWord;
    endcase
  end

  assign memWe = (stateQ == StBusy) && (cntQ == 4'd0) && writeQ && !accessErr;

  always_ff @(posedge Clk) begin
    if (memWe) mem[idx] <= storeWord;
  end

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    writeD  = writeQ;
    addrD   = addrQ;
    wdataD  = wdataQ;
    sizeD   = sizeQ;
    signedD = signedQ;
    rdataD  = rdataQ;
    errD    = errQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.ReqValid) begin
          writeD  = bus.ReqWrite;
          addrD   = bus.ReqAddress;
          wdataD  = bus.ReqWriteData;
          sizeD   = bus.ReqSize;
          signedD = bus.ReqSigned;
          cntD    = WaitW;
          stateD  = StBusy;
        end
      end
      StBusy: begin
        if (cntQ != 4'd0) begin
          cntD = cntQ - 4'd1;
        end else begin
          rdataD = (accessErr || writeQ) ? 32'd0 : loadData;
          errD   = accessErr;
          stateD = StResp;
        end
      end
      StResp: begin
        if (bus.RespReady) begin
          rdataD = '0;
          errD   = 1'b0;
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      writeQ  <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      sizeQ   <= '0;
      signedQ <= 1'b0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      writeQ  <= writeD;
      addrQ   <= addrD;
      wdataQ  <= wdataD;
      sizeQ   <= sizeD;
      signedQ <= signedD;
      rdataQ  <= rdataD;
      errQ    <= errD;
    end
  end

  assign bus.ReqReady     = (stateQ == StIdle);
  assign bus.RespValid    = (stateQ == StResp);
  assign bus.RespReadData = rdataQ;
  assign bus.RespError    = errQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with WAIT_CYCLES=2 (response 3 edges after accept).
module tb_data_mem_responder;

  logic Clk;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(2)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic idleInputs();
    bus.ReqValid     = 1'b0;
    bus.ReqWrite     = 1'b0;
    bus.ReqAddress   = '0;
    bus.ReqWriteData = '0;
    bus.ReqSize      = 2'b10;
    bus.ReqSigned    = 1'b0;
    bus.RespReady    = 1'b0;
  endtask

  // Full transaction; lat counts edges from the accept edge to RespValid high.
  task automatic doReq(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sgn,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    rdata = 'x;
    err   = 1'bx;
    lat   = -1;
    @(negedge Clk);
    bus.ReqValid     = 1'b1;
    bus.ReqWrite     = wr;
    bus.ReqAddress   = addr;
    bus.ReqWriteData = wdata;
    bus.ReqSize      = size;
    bus.ReqSigned    = sgn;
    n = 0;
    while (!bus.ReqReady && n < 50) begin
      @(negedge Clk);
      n++;
    end
    @(posedge Clk);
    #1 bus.ReqValid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge Clk);
      #1 n++;
      if (bus.RespValid) break;
    end
    if (!bus.RespValid) begin
      errors++;
      checks++;
      $display("FAIL resp_timeout addr=%h got RespValid=0 want 1", addr);
      return;
    end
    lat   = n;
    rdata = bus.RespReadData;
    err   = bus.RespError;
    bus.RespReady = 1'b1;
    @(posedge Clk);
    #1 bus.RespReady = 1'b0;
  endtask

  task automatic expectResp(input string name, input logic [31:0] rdata, input logic err,
                            input int lat, input logic [31:0] wantData, input logic wantErr);
    checks++;
    if (rdata !== wantData || err !== wantErr || lat !== 3) begin
      errors++;
      $display("FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=3",
               name, rdata, err, lat, wantData, wantErr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    int          l;
    Reset = 1'b0;
    idleInputs();
    repeat (3) @(posedge Clk);
    #1 checks++;
    if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0 || bus.RespReadData !== 32'd0 ||
        bus.RespError !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got rdy=%b vld=%b data=%h err=%b want 1 0 0 0",
               bus.ReqReady, bus.RespValid, bus.RespReadData, bus.RespError);
    end
    @(negedge Clk) Reset = 1'b1;
    doReq(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, d, e, l);
    expectResp("reset_prestore", d, e, l, 32'h0, 1'b0);
    // Accept a store, then pull reset one cycle later before it commits.
    @(negedge Clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqAddress = 32'h20;
    bus.ReqWriteData = 32'hDEADBEEF; bus.ReqSize = 2'b10;
    @(posedge Clk);
    #1 bus.ReqValid = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b0;
    #1 checks++;
    if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0 || bus.RespReadData !== 32'd0 ||
        bus.RespError !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b data=%h err=%b want 1 0 0 0",
               bus.ReqReady, bus.RespValid, bus.RespReadData, bus.RespError);
    end
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    doReq(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, d, e, l);
    expectResp("reset_store_dropped", d, e, l, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_round_trip();
    logic [31:0] d;
    logic        e;
    int          l;
    doReq(1'b1, 32'h10, 32'h12345678, 2'b10, 1'b0, d, e, l);
    expectResp("rt_store", d, e, l, 32'h0, 1'b0);
    doReq(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, d, e, l);
    expectResp("rt_load", d, e, l, 32'h12345678, 1'b0);
  endtask

  task automatic test_lanes();
    logic [31:0] d;
    logic        e;
    int          l;
    doReq(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, d, e, l);
    expectResp("lane_byte1_signed", d, e, l, 32'h00000056, 1'b0);
    doReq(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, d, e, l);
    expectResp("lane_half_hi", d, e, l, 32'h00001234, 1'b0);
    doReq(1'b1, 32'h13, 32'hAABBCCFF, 2'b00, 1'b0, d, e, l);
    expectResp("lane_store_byte3", d, e, l, 32'h0, 1'b0);
    doReq(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, d, e, l);
    expectResp("lane_word_after", d, e, l, 32'hFF345678, 1'b0);
  endtask

  task automatic test_sign();
    logic [31:0] d;
    logic        e;
    int          l;
    doReq(1'b1, 32'h40, 32'h000080F0, 2'b10, 1'b0, d, e, l);
    expectResp("sign_store", d, e, l, 32'h0, 1'b0);
    doReq(1'b0, 32'h40, 32'h0, 2'b00, 1'b1, d, e, l);
    expectResp("sign_byte", d, e, l, 32'hFFFFFFF0, 1'b0);
    doReq(1'b0, 32'h40, 32'h0, 2'b01, 1'b1, d, e, l);
    expectResp("sign_half", d, e, l, 32'hFFFF80F0, 1'b0);
    doReq(1'b0, 32'h40, 32'h0, 2'b01, 1'b0, d, e, l);
    expectResp("zero_half", d, e, l, 32'h000080F0, 1'b0);
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e;
    int          l;
    doReq(1'b1, 32'h0, 32'h0BADF00D, 2'b10, 1'b0, d, e, l);
    expectResp("err_prestore", d, e, l, 32'h0, 1'b0);
    doReq(1'b0, 32'h02, 32'h0, 2'b10, 1'b0, d, e, l);
    expectResp("err_word_misaligned", d, e, l, 32'h0, 1'b1);
    doReq(1'b0, 32'h41, 32'h0, 2'b01, 1'b0, d, e, l);
    expectResp("err_half_misaligned", d, e, l, 32'h0, 1'b1);
    doReq(1'b1, 32'h1000, 32'h11111111, 2'b10, 1'b0, d, e, l);
    expectResp("err_out_of_range", d, e, l, 32'h0, 1'b1);
    doReq(1'b1, 32'h0, 32'hFFFFFFFF, 2'b11, 1'b0, d, e, l);
    expectResp("err_size11", d, e, l, 32'h0, 1'b1);
    doReq(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, d, e, l);
    expectResp("err_word0_intact", d, e, l, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge Clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAddress = 32'h10;
    bus.ReqSize = 2'b10; bus.ReqSigned = 1'b0;
    @(posedge Clk);
    // Present a second request immediately and keep it asserted.
    #1 bus.ReqAddress = 32'h40;
    n = 0;
    while (n < 50) begin
      @(posedge Clk);
      #1 n++;
      if (bus.RespValid) break;
    end
    checks++;
    if (n !== 3 || bus.RespValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_latency got lat=%0d vld=%b want lat=3 vld=1", n, bus.RespValid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1 checks++;
      if (bus.RespValid !== 1'b1 || bus.RespReadData !== 32'hFF345678 ||
          bus.ReqReady !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b data=%h rdy=%b want 1 ff345678 0",
                 i, bus.RespValid, bus.RespReadData, bus.ReqReady);
      end
    end
    bus.RespReady = 1'b1;
    @(posedge Clk);
    #1 bus.RespReady = 1'b0;
    checks++;
    if (bus.RespValid !== 1'b0 || bus.ReqReady !== 1'b1 || bus.RespReadData !== 32'd0) begin
      errors++;
      $display("FAIL bp_handshake got vld=%b rdy=%b data=%h want 0 1 0",
               bus.RespValid, bus.ReqReady, bus.RespReadData);
    end
    @(posedge Clk);
    #1 bus.ReqValid = 1'b0;
    checks++;
    if (bus.ReqReady !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got rdy=%b want 0", bus.ReqReady);
    end
    n = 0;
    while (n < 50) begin
      @(posedge Clk);
      #1 n++;
      if (bus.RespValid) break;
    end
    checks++;
    if (n !== 3 || bus.RespReadData !== 32'h000080F0 || bus.RespError !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_resp got lat=%0d data=%h err=%b want lat=3 data=000080f0 err=0",
               n, bus.RespReadData, bus.RespError);
    end
    bus.RespReady = 1'b1;
    @(posedge Clk);
    #1 bus.RespReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_lanes();
    test_sign();
    test_errors();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port, i.e. the slave end of the load/store interface.
- Accepts one load or store request per transaction over a valid/ready handshake and returns a response after a fixed, parameterised number of wait cycles.
- Supports byte, half and word accesses and reports misaligned or out-of-range accesses.
- Lets the pipeline be exercised against a realistic multi-cycle memory instead of a zero-latency array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; valid word index is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, extra cycles spent in BUSY before the access is performed; range 0..15.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  responder can accept a request.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqAddress  input  32  byte address.
- ReqWriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ReqSize  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- ReqSigned  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- RespValid  output  1  response present.
- RespReady  input  1  requester accepts the response.
- RespReadData  output  32  load result; 0 for stores and for errors.
- RespError  output  1  misaligned access, out-of-range access or illegal size.

Behaviour:
- One clock domain, Clk. Reset is asynchronous, active-low.
- While Reset is low:
  - state = IDLE, ReqReady = 1, RespValid = 0, RespReadData = 0, RespError = 0, wait counter = 0.
  - Memory contents are not cleared.
- State IDLE:
  - ReqReady = 1.
  - When ReqValid = 1 at a rising edge, the request is accepted. ReqWrite, ReqAddress, ReqWriteData, ReqSize and ReqSigned are captured into internal registers.
  - The counter loads WAIT_CYCLES and the state moves to BUSY.
- State BUSY:
  - ReqReady = 0. Request inputs are ignored.
  - If counter != 0, decrement.
  - If counter == 0, perform the access at that edge, register RespReadData and RespError, set RespValid = 1, and move to RESP.
- State RESP:
  - RespValid = 1. RespReadData and RespError are held stable until the handshake completes.
  - When RespReady = 1 at a rising edge: RespValid -> 0, RespReadData -> 0, RespError -> 0, state -> IDLE.
- Latency and throughput:
  - Request accepted at edge N gives RespValid high after edge N+1+WAIT_CYCLES.
  - Minimum spacing between accepts is WAIT_CYCLES+3 edges.
- Error detection, evaluated on the captured request:
  - ReqSize = 11.
  - Half access with address[0] = 1.
  - Word access with address[1:0] != 00.
  - Word index address[31:2] >= DEPTH_WORDS.
  - On error: no memory write occurs, RespReadData = 0, RespError = 1.
- Byte lanes are little-endian: lane = address[1:0]; byte k occupies bits [8k+7:8k] of the word.
- Store byte: only lane address[1:0] is written, from ReqWriteData[7:0].
- Store half: lanes {address[1],0} and {address[1],1} are written, from ReqWriteData[15:0].
- Store word: all lanes are written.
- Store response: RespReadData = 0.
- Load: the selected byte or half is right-aligned, then sign- or zero-extended per ReqSigned. ReqSigned is ignored for word loads.
- Reset asserted in BUSY before the commit edge: the pending store is dropped and memory is unchanged.
- Reset asserted in RESP: the response is discarded.
- ReqValid held high in BUSY or RESP is not accepted. The requester must hold the request until it sees ReqReady = 1 at an edge.
- RespReady high while not in RESP has no effect.

Test Plan:
- Reset mid-operation:
  - Stimulus: with WAIT_CYCLES=2, assert Reset low one cycle after accepting a store of 0xDEADBEEF to 0x20; then load word 0x20.
  - Required response: the load returns the pre-existing contents and RespError = 0.
  - Reset check: ReqReady = 1, RespValid = 0, RespReadData = 0, RespError = 0 while Reset is low.
- Store/load round trip and latency:
  - Stimulus: store word 0x12345678 to 0x10, then load word 0x10.
  - Required response: RespValid rises exactly 3 edges after each accept, and the load returns 0x12345678.
- Byte and half lanes:
  - Stimulus: after the previous scenario, load byte 0x11 signed; load half 0x12 zero-extended; store byte 0xFF to 0x13; load word 0x10.
  - Required responses, in order: 0x00000056, 0x00001234, then 0xFF345678.
- Sign extension:
  - Stimulus: store word 0x0000_80F0 to 0x40; load byte 0x40 signed; load half 0x40 signed; load half 0x40 unsigned.
  - Required responses, in order: 0xFFFFFFF0, 0xFFFF80F0, 0x000080F0.
- Errors:
  - Stimulus: load word 0x02; load half 0x41; store word to 0x1000 (index 1024); access with ReqSize = 11.
  - Required response: each returns RespError = 1 and RespReadData = 0.
  - Follow-up: a load of word 0x0 afterwards is unchanged.
- Back-pressure:
  - Stimulus: load with RespReady held low for 5 cycles while ReqValid stays high with a second request.
  - Required response: RespValid and RespReadData remain stable for the 5 cycles, and ReqReady stays 0.
  - Required response: the second request is accepted only on the first edge after the response handshake.
